// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory arbiter: arbiter states, port owner tags
// and the memory word size.
package imem_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_LOCK  = 2'd2
    } imem_arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LD = 1'b1
    } imem_owner_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/imem_addr_check.sv
// Combinational legality check for one request port: the byte address must be word
// aligned and name a whole word inside the memory.
module imem_addr_check
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              ok
);

    localparam int unsigned       ALIGN_W   = $clog2(WORD_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

    // Aligned and not past the last full word
    always_comb begin
        ok = (addr[ALIGN_W-1:0] == {ALIGN_W{1'b0}}) && (addr <= LAST_WORD);
    end

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one 1-cycle synchronous-read instruction memory between
// the core fetch port and a loader/debug port, with fetch flush and an exclusive loader lock.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic              ld_req_we,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [DATA_W-1:0] ld_req_wdata,
    input  logic              ld_lock,
    output logic              ld_locked,
    output logic              ld_rsp_valid,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic              ld_rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    imem_arb_state_e state_q, state_d;
    imem_owner_e     rr_last_q, rr_last_d;
    imem_owner_e     rsp_own_q, rsp_own_d;
    logic            rsp_pend_q, rsp_pend_d;
    logic            rsp_err_q, rsp_err_d;
    logic            rsp_wr_q, rsp_wr_d;
    logic            rsp_kill_q, rsp_kill_d;
    logic            if_ok_s, ld_ok_s;
    logic            if_allow_s, if_gnt_s, ld_gnt_s;

    imem_addr_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_if_chk (
        .addr (if_req_addr),
        .ok   (if_ok_s)
    );

    imem_addr_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_ld_chk (
        .addr (ld_req_addr),
        .ok   (ld_ok_s)
    );

    // Grant selection: fetch competes only in S_RUN; on conflict the port not in rr_last wins
    always_comb begin
        if_allow_s = (state_q == S_RUN);
        if_gnt_s   = 1'b0;
        ld_gnt_s   = 1'b0;
        if (if_req_valid && if_allow_s && ld_req_valid) begin
            if (rr_last_q == OWN_LD) begin
                if_gnt_s = 1'b1;
            end else begin
                ld_gnt_s = 1'b1;
            end
        end else if (if_req_valid && if_allow_s) begin
            if_gnt_s = 1'b1;
        end else begin
            ld_gnt_s = ld_req_valid;
        end
        if_req_ready = if_gnt_s;
        ld_req_ready = ld_gnt_s;
    end

    // Memory drive: illegal accesses are accepted but never reach the memory
    always_comb begin
        mem_en    = (if_gnt_s && if_ok_s) || (ld_gnt_s && ld_ok_s);
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (ld_gnt_s && ld_ok_s) begin
            mem_we    = ld_req_we;
            mem_addr  = ld_req_addr;
            mem_wdata = ld_req_we ? ld_req_wdata : {DATA_W{1'b0}};
        end else if (if_gnt_s && if_ok_s) begin
            mem_addr = if_req_addr;
        end else begin
            mem_addr = {ADDR_W{1'b0}};
        end
    end

    // In-flight access record and round-robin pointer
    always_comb begin
        rsp_pend_d = if_gnt_s || ld_gnt_s;
        rsp_own_d  = ld_gnt_s ? OWN_LD : OWN_IF;
        rsp_err_d  = ld_gnt_s ? !ld_ok_s : (if_gnt_s && !if_ok_s);
        rsp_wr_d   = ld_gnt_s && ld_req_we;
        rsp_kill_d = if_gnt_s && if_flush;
        if (if_req_valid && ld_req_valid && if_allow_s) begin
            rr_last_d = ld_gnt_s ? OWN_LD : OWN_IF;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Lock sequencing: drain outstanding fetch, hold lock until the loader is idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (ld_lock) state_d = S_DRAIN;
                else         state_d = S_RUN;
            end
            S_DRAIN: begin
                if (!ld_lock)                                     state_d = S_RUN;
                else if (!(rsp_pend_q && rsp_own_q == OWN_IF))    state_d = S_LOCK;
                else                                              state_d = S_DRAIN;
            end
            S_LOCK: begin
                if (!ld_lock && !rsp_pend_q && !ld_gnt_s) state_d = S_RUN;
                else                                      state_d = S_LOCK;
            end
            default: state_d = S_RUN;
        endcase
    end

    // State registers; reset drops any in-flight response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            rr_last_q  <= OWN_LD;
            rsp_own_q  <= OWN_IF;
            rsp_pend_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_wr_q   <= 1'b0;
            rsp_kill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            rsp_own_q  <= rsp_own_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_err_q  <= rsp_err_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_kill_q <= rsp_kill_d;
        end
    end

    // Response steering: a late flush still kills the fetch strobe in its delivery cycle
    always_comb begin
        if_rsp_valid = rsp_pend_q && (rsp_own_q == OWN_IF) && !rsp_kill_q && !if_flush;
        if_rsp_err   = if_rsp_valid && rsp_err_q;
        if_rsp_data  = (if_rsp_valid && !rsp_err_q) ? mem_rdata : {DATA_W{1'b0}};
        ld_rsp_valid = rsp_pend_q && (rsp_own_q == OWN_LD);
        ld_rsp_err   = ld_rsp_valid && rsp_err_q;
        ld_rsp_data  = (ld_rsp_valid && !rsp_err_q && !rsp_wr_q) ? mem_rdata : {DATA_W{1'b0}};
        ld_locked    = (state_q == S_LOCK);
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic
// checked against a request-queue / expected-response reference model.
module tb_imem_arbiter;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        ld_req_valid, ld_req_ready, ld_req_we, ld_lock, ld_locked, ld_rsp_valid, ld_rsp_err;
    logic [31:0] ld_req_addr, ld_req_wdata, ld_rsp_data;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .if_rsp_err(if_rsp_err),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_we(ld_req_we),
        .ld_req_addr(ld_req_addr), .ld_req_wdata(ld_req_wdata), .ld_lock(ld_lock),
        .ld_locked(ld_locked), .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .ld_rsp_err(ld_rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // External memory: word array, synchronous 1-cycle read
    logic [31:0] mem_w  [0:255];
    logic [31:0] init_w [0:255];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_w[i] <= init_w[i];
        end else if (mem_en) begin
            if (mem_we) mem_w[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem_w[mem_addr[9:2]];
        end
    end

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { int due; bit is_ld; bit err; logic [31:0] data; bit killed; } rsp_t;

    req_t        if_q[$];
    req_t        ld_q[$];
    rsp_t        rsp_q[$];
    logic [1:0]  obs_log[$];
    logic [31:0] exp_mem [0:255];
    bit          last_ld;
    int          cyc, checks, errors, mem_en_cnt, n;
    logic [31:0] last_if_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a <= 32'(MEM_BYTES - 4));
    endfunction

    function automatic req_t mk(input bit we, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.we = we; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic logic [31:0] rnd_addr();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s == 0)      return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (s == 1) return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC
                                : 32'h400 + 32'($urandom_range(0, 63)) * 32'd4;
        else             return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    // One clock of traffic: present queue heads, check responses and grants against the model
    task automatic run_cycle(input bit flush);
        req_t ir, lr;
        rsp_t r, nr;
        bit   iv, lv, gi, gl, found, e_ifv, e_ldv, ok;
        @(posedge clk); #1;
        cyc++;
        iv = (if_q.size() > 0);
        lv = (ld_q.size() > 0);
        ir = iv ? if_q[0] : '0;
        lr = lv ? ld_q[0] : '0;
        if_req_valid = iv;   if_req_addr  = ir.addr;
        ld_req_valid = lv;   ld_req_we    = lr.we;
        ld_req_addr  = lr.addr; ld_req_wdata = lr.wdata;
        if_flush     = flush;
        found = 1'b0;
        r = '{default: 0};
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            found = 1'b1;
        end
        #4;
        e_ifv = found && !r.is_ld && !r.killed && !flush;
        e_ldv = found && r.is_ld;
        check("if_rsp_valid", 32'(if_rsp_valid), 32'(e_ifv));
        check("ld_rsp_valid", 32'(ld_rsp_valid), 32'(e_ldv));
        if (e_ifv) begin
            check("if_rsp_err", 32'(if_rsp_err), 32'(r.err));
            check("if_rsp_data", if_rsp_data, r.data);
            last_if_data = if_rsp_data;
        end
        if (e_ldv) begin
            check("ld_rsp_err", 32'(ld_rsp_err), 32'(r.err));
            check("ld_rsp_data", ld_rsp_data, r.data);
        end
        gi = iv && (!lv || last_ld);
        gl = lv && !gi;
        obs_log.push_back({if_req_ready, ld_req_ready});
        check("if_req_ready", 32'(if_req_ready), 32'(gi));
        check("ld_req_ready", 32'(ld_req_ready), 32'(gl));
        ok = gi ? legal(ir.addr) : (gl ? legal(lr.addr) : 1'b0);
        check("mem_en", 32'(mem_en), 32'(ok));
        if (mem_en === 1'b1) mem_en_cnt++;
        if (gi || gl) begin
            nr.due    = cyc + 1;
            nr.is_ld  = gl;
            nr.err    = !ok;
            nr.killed = gi && flush;
            if (!ok || (gl && lr.we)) nr.data = 32'd0;
            else                      nr.data = exp_mem[gi ? ir.addr[9:2] : lr.addr[9:2]];
            if (gl && lr.we && ok) exp_mem[lr.addr[9:2]] = lr.wdata;
            rsp_q.push_back(nr);
            if (iv && lv) last_ld = gl;
            if (gi) void'(if_q.pop_front());
            else    void'(ld_q.pop_front());
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((if_q.size() + ld_q.size() + rsp_q.size()) > 0 && k < 50) begin
            run_cycle(1'b0);
            k++;
        end
        check("drain_done", 32'(if_q.size() + ld_q.size() + rsp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 32'd0; if_flush = 1'b0;
        ld_req_valid = 1'b0; ld_req_we = 1'b0; ld_req_addr = 32'd0; ld_req_wdata = 32'd0;
        ld_lock = 1'b0;
        #1;
        check("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        check("rst_ld_rsp_valid", 32'(ld_rsp_valid), 32'd0);
        check("rst_ld_locked", 32'(ld_locked), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        if_q.delete(); ld_q.delete(); rsp_q.delete();
        last_ld = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; mem_en_cnt = 0; last_if_data = 32'd0;
        rst_n = 1'b0; preload = 1'b1; ld_lock = 1'b0;
        if_req_valid = 1'b0; if_req_addr = 32'd0; if_flush = 1'b0;
        ld_req_valid = 1'b0; ld_req_we = 1'b0; ld_req_addr = 32'd0; ld_req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            init_w[i]  = $urandom;
            exp_mem[i] = init_w[i];
        end
        @(posedge clk); #1 preload = 1'b0;
        apply_reset();

        // Fetch-only stream 0x0, 0x4, 0x8
        if_q.push_back(mk(1'b0, 32'h0, 32'd0));
        if_q.push_back(mk(1'b0, 32'h4, 32'd0));
        if_q.push_back(mk(1'b0, 32'h8, 32'd0));
        repeat (4) run_cycle(1'b0);
        check("stream_last_word", last_if_data, init_w[2]);

        // Both ports busy: IF, LD, IF, LD
        apply_reset();
        obs_log.delete();
        if_q.push_back(mk(1'b0, 32'h20, 32'd0));
        if_q.push_back(mk(1'b0, 32'h24, 32'd0));
        ld_q.push_back(mk(1'b0, 32'h30, 32'd0));
        ld_q.push_back(mk(1'b0, 32'h34, 32'd0));
        repeat (4) run_cycle(1'b0);
        check("rr_order", 32'({obs_log[0], obs_log[1], obs_log[2], obs_log[3]}), 32'b10_01_10_01);
        drain();

        // Loader write then fetch of the same word
        last_if_data = 32'd0;
        ld_q.push_back(mk(1'b1, 32'h10, 32'hDEAD_BEEF));
        run_cycle(1'b0);
        if_q.push_back(mk(1'b0, 32'h10, 32'd0));
        drain();
        check("write_then_fetch", last_if_data, 32'hDEAD_BEEF);

        // Misaligned and out-of-range fetches never touch memory
        mem_en_cnt = 0;
        if_q.push_back(mk(1'b0, 32'h2, 32'd0));
        if_q.push_back(mk(1'b0, 32'h400, 32'd0));
        drain();
        check("illegal_mem_en_count", 32'(mem_en_cnt), 32'd0);

        // Flush in response cycle, flush in acceptance cycle, then a normal fetch
        last_if_data = 32'd0;
        if_q.push_back(mk(1'b0, 32'h20, 32'd0));
        run_cycle(1'b0);
        run_cycle(1'b1);
        if_q.push_back(mk(1'b0, 32'h28, 32'd0));
        run_cycle(1'b1);
        run_cycle(1'b0);
        check("flushed_no_data", last_if_data, 32'd0);
        if_q.push_back(mk(1'b0, 32'h24, 32'd0));
        drain();
        check("after_flush", last_if_data, exp_mem[9]);

        // Loader lock with a fetch in flight
        apply_reset();
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h8;
        #4 check("lk_fetch_gnt", 32'(if_req_ready), 32'd1);
        @(posedge clk); #1;
        if_req_valid = 1'b0; ld_lock = 1'b1;
        #4;
        check("lk_fetch_rsp", 32'(if_rsp_valid), 32'd1);
        check("lk_not_yet", 32'(ld_locked), 32'd0);
        n = 0;
        while (ld_locked !== 1'b1 && n < 4) begin
            @(posedge clk); #5;
            n++;
        end
        check("lk_locked", 32'(ld_locked), 32'd1);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'h8;
        ld_req_valid = 1'b1; ld_req_we = 1'b1; ld_req_addr = 32'h40; ld_req_wdata = 32'h1234_5678;
        #4;
        check("lk_if_blocked", 32'(if_req_ready), 32'd0);
        check("lk_ld_gnt", 32'(ld_req_ready), 32'd1);
        exp_mem[16] = 32'h1234_5678;
        @(posedge clk); #1;
        ld_req_valid = 1'b0;
        #4;
        check("lk_ld_ack", 32'(ld_rsp_valid), 32'd1);
        check("lk_ld_ack_data", ld_rsp_data, 32'd0);
        check("lk_if_still_blocked", 32'(if_req_ready), 32'd0);
        @(posedge clk); #1;
        ld_lock = 1'b0;
        n = 0;
        while (if_req_ready !== 1'b1 && n < 4) begin
            @(posedge clk); #5;
            n++;
        end
        check("unlk_if_gnt", 32'(if_req_ready), 32'd1);
        check("unlk_unlocked", 32'(ld_locked), 32'd0);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        #4;
        check("unlk_rsp_valid", 32'(if_rsp_valid), 32'd1);
        check("unlk_rsp_data", if_rsp_data, exp_mem[2]);

        // Reset in the middle of an access
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_addr = 32'hC;
        #4 check("mid_gnt", 32'(if_req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; if_req_valid = 1'b0;
        #1;
        check("mid_rst_if_rsp", 32'(if_rsp_valid), 32'd0);
        check("mid_rst_mem_en", 32'(mem_en), 32'd0);
        check("mid_rst_ready", 32'(if_req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #4;
            check("post_rst_if_rsp", 32'(if_rsp_valid), 32'd0);
            check("post_rst_ld_rsp", 32'(ld_rsp_valid), 32'd0);
        end

        // Randomized mixed traffic
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            if (if_q.size() == 0 && $urandom_range(0, 3) != 0)
                if_q.push_back(mk(1'b0, rnd_addr(), 32'd0));
            if (ld_q.size() == 0 && $urandom_range(0, 2) == 0)
                ld_q.push_back(mk(1'($urandom_range(0, 1)), rnd_addr(), $urandom));
            run_cycle($urandom_range(0, 6) == 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
